fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter RESET_ADDR, default 32'h00000000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving queue entries and the maximum in-flight requests; legal values are powers of two, 2 or more.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port o_mem_req, output, 1 bit: instruction memory request valid.
REQ-006 The block SHALL have port o_mem_addr, output, 32 bits: word-aligned fetch address.
REQ-007 The block SHALL have port i_mem_ready, input, 1 bit: memory accepts the request this cycle.
REQ-008 The block SHALL have port i_mem_valid, input, 1 bit: one in-order response word this cycle.
REQ-009 The block SHALL have port i_mem_rdata, input, 32 bits: response instruction word.
REQ-010 The block SHALL have port o_inst_valid, output, 1 bit: the queue head is valid.
REQ-011 The block SHALL have port o_inst, output, 32 bits: head instruction word.
REQ-012 The block SHALL have port o_inst_pc, output, 32 bits: head PC.
REQ-013 The block SHALL have port o_inst_trap, output, 1 bit: head carries a misaligned-fetch trap.
REQ-014 The block SHALL have port i_inst_ready, input, 1 bit: hart consumes the head this cycle.
REQ-015 The block SHALL have port i_redirect, input, 1 bit: taken branch/jump, flush request.
REQ-016 The block SHALL have port i_redirect_pc, input, 32 bits: new fetch PC.

Function
REQ-017 The block SHALL accept a request on o_mem_req and i_mem_ready both high; on acceptance fetch_pc SHALL advance by 4 and outstanding SHALL increment.
REQ-018 o_mem_req SHALL be high only when count+outstanding < DEPTH, i_redirect is low, and the block is not trap-stalled.
REQ-019 Once high, o_mem_req and o_mem_addr SHALL stay stable until accepted, except when a redirect drops the request.
REQ-020 Each i_mem_valid SHALL decrement outstanding; if drop_cnt is 0 it SHALL push {rdata, resp_pc} and set resp_pc to resp_pc+4; otherwise it SHALL discard the word and decrement drop_cnt.
REQ-021 On o_inst_valid and i_inst_ready both high, the head SHALL pop; o_inst_valid SHALL equal (count != 0).
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; the credit check in REQ-018 SHALL ensure overflow never occurs.
REQ-023 Head-to-output latency SHALL be zero (registered storage, combinational read); response-to-o_inst_valid latency SHALL be one cycle.
REQ-024 On i_redirect: the queue SHALL empty; fetch_pc and resp_pc SHALL load i_redirect_pc; drop_cnt SHALL load outstanding minus any response arriving that cycle; any pop that cycle SHALL be ignored.
REQ-025 A redirect while drop_cnt is nonzero SHALL add the new in-flight count to drop_cnt; no stale word SHALL ever reach o_inst.
REQ-026 count, outstanding and drop_cnt SHALL each be $clog2(DEPTH)+1 bits wide; PC arithmetic SHALL wrap modulo 2^32.

Reset
REQ-027 Reset SHALL set fetch_pc and resp_pc to RESET_ADDR and set count, outstanding, drop_cnt and the trap-stall flag to 0.
REQ-028 During reset o_mem_req, o_inst_valid and o_inst_trap SHALL be 0; the first request SHALL issue the cycle after reset deasserts.
REQ-029 Reset mid-operation SHALL abandon in-flight requests; the memory side SHALL be reset with the block.

Configuration
REQ-030 With FETCH_QUEUE_MISALIGN_TRAP_EN defined, a redirect with i_redirect_pc[1:0] != 0 SHALL enqueue one entry with o_inst_trap=1, o_inst=0 and o_inst_pc=i_redirect_pc, then suppress requests until the next redirect.
REQ-031 Without FETCH_QUEUE_MISALIGN_TRAP_EN, i_redirect_pc[1:0] SHALL be forced to 0 and o_inst_trap SHALL be tied to 0.

Structure
REQ-032 Shared package hart_pkg SHALL hold XLEN=32, INST_BYTES=4 and the default RESET_ADDR.
REQ-033 Queue storage SHALL be a sub-module sync_fifo (parameters WIDTH and DEPTH, with flush), instantiated with WIDTH=65 for {trap, pc, inst}.

Verification
REQ-034 Reset scenario: release reset with RESET_ADDR=0x100 and the memory always ready -> o_mem_addr is 0x100, 0x104, 0x108, 0x10C, then o_mem_req drops with 4 in flight.
REQ-035 Full-queue scenario: hold i_inst_ready=0 with responses returning -> count reaches 4, o_mem_req stays 0; one pop -> exactly one new request.
REQ-036 Flush scenario: with 3 outstanding, pulse i_redirect with i_redirect_pc=0x200 -> the 3 late responses are discarded and the first popped entry has o_inst_pc=0x200.
REQ-037 Simultaneous-event scenario: redirect in the same cycle as a response and a pop -> the queue is empty, drop_cnt equals old outstanding minus 1, and the next fetch is at the redirect PC.
REQ-038 Misalign scenario: with FETCH_QUEUE_MISALIGN_TRAP_EN defined, redirect to 0x202 -> a single entry with o_inst_trap=1 and o_inst_pc=0x202, and no requests until a redirect to 0x300.
REQ-039 Back-pressure scenario: i_mem_ready held 0 for 5 cycles -> o_mem_addr stays at 0x104 and fetch_pc does not advance.

Source files
------------

// File: rtl/hart_pkg.sv
// Shared hart-wide constants and the fetch queue entry layout.
package hart_pkg;
    localparam int              XLEN               = 32;
    localparam logic [XLEN-1:0] INST_BYTES         = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

    typedef struct packed {
        logic            trap;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fq_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Register-based FIFO with combinational head read and a flush that may
// coincide with a push (the pushed word becomes the only entry).
module sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               rd_ptr, wr_ptr;
    logic [CW-1:0]               count;
    logic                        pop_ok;

    assign pop_ok  = i_pop && (count != '0);
    assign o_dout  = mem[rd_ptr];
    assign o_count = count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= AW'(i_push);
            count  <= CW'(i_push);
        end else begin
            if (i_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(i_push) - CW'(pop_ok);
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge i_clk) begin
        if (i_push) mem[i_flush ? AW'(0) : wr_ptr] <= i_din;
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue with credit-limited requests and redirect flush.
// Optional misaligned-redirect trap: define FETCH_QUEUE_MISALIGN_TRAP_EN.
module fetch_queue
    import hart_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = DEFAULT_RESET_ADDR,
    parameter int              DEPTH      = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    input  logic            i_mem_ready,
    input  logic            i_mem_valid,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_inst_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    output logic            o_inst_trap,
    input  logic            i_inst_ready,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc, resp_pc, redirect_pc;
    logic [CW-1:0]   count, outstanding, drop_cnt;
    logic            trap_stall, misalign, accept, push, pop;
    fq_entry_t       push_entry, head;

`ifdef FETCH_QUEUE_MISALIGN_TRAP_EN
    assign misalign    = i_redirect && (i_redirect_pc[1:0] != 2'b00);
    assign redirect_pc = i_redirect_pc;
    assign o_inst_trap = o_inst_valid && head.trap;
`else
    logic unused_bits;
    assign misalign    = 1'b0;
    assign redirect_pc = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign o_inst_trap = 1'b0;
    assign unused_bits = &{1'b0, head.trap, i_redirect_pc[1:0]};
`endif

    // Credit check counts queued plus in-flight words so the FIFO never overflows.
    assign o_mem_req  = !i_rst && !i_redirect && !trap_stall &&
                        (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
    assign o_mem_addr = fetch_pc;
    assign accept     = o_mem_req && i_mem_ready;

    assign o_inst_valid = (count != '0);
    assign o_inst       = head.inst;
    assign o_inst_pc    = head.pc;

    assign pop  = o_inst_valid && i_inst_ready && !i_redirect;
    assign push = misalign || (i_mem_valid && (drop_cnt == '0) && !i_redirect);

    always_comb begin
        push_entry = '{trap: 1'b0, pc: resp_pc, inst: i_mem_rdata};
        if (misalign) push_entry = '{trap: 1'b1, pc: i_redirect_pc, inst: '0};
    end

    sync_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_redirect),
        .i_push  (push),
        .i_din   (push_entry),
        .i_pop   (pop),
        .o_dout  (head),
        .o_count (count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc    <= RESET_ADDR;
            resp_pc     <= RESET_ADDR;
            outstanding <= '0;
            drop_cnt    <= '0;
            trap_stall  <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(i_mem_valid);
            if (i_redirect) begin
                fetch_pc   <= redirect_pc;
                resp_pc    <= redirect_pc;
                // Everything still in flight after this cycle is stale.
                drop_cnt   <= outstanding - CW'(i_mem_valid);
                trap_stall <= misalign;
            end else begin
                if (accept) fetch_pc <= fetch_pc + INST_BYTES;
                if (i_mem_valid) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                    else                resp_pc  <= resp_pc + INST_BYTES;
                end
            end
        end
    end
endmodule
